sdram_frame_reader: RTL and testbench
=====================================

SDRAM_FRAME_READER -- requirements
Module: sdram_frame_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SDRAM word width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first word address of the frame.
REQ-004 SHALL have parameter FRAME_WORDS, default 19200, words per frame; must be a multiple of BURST_LEN.
REQ-005 SHALL have parameter BURST_LEN, default 8, words returned per grant.
REQ-006 SHALL have parameter FIFO_DEPTH, default 32, power of two, at least 2*BURST_LEN.
REQ-007 SHALL have port iCLK, input, 1 bit: the only clock.
REQ-008 SHALL have port iRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port iENABLE, input, 1 bit: allows new read requests.
REQ-010 SHALL have port iFRAME_START, input, 1 bit: single-cycle pulse that restarts at BASE_ADDR.
REQ-011 SHALL have port oRD_REQ, output, 1 bit: read request to the controller read agent.
REQ-012 SHALL have port iRD_GNT, input, 1 bit: controller accepts the request.
REQ-013 SHALL have port oRD_ADDR, output, ADDR_W bits: burst start address.
REQ-014 SHALL have port iRD_DATA, input, DATA_W bits: returned word.
REQ-015 SHALL have port iRD_DATA_VALID, input, 1 bit: iRD_DATA is valid this cycle.
REQ-016 SHALL have port iPIX_REQ, input, 1 bit: consumer pops one word.
REQ-017 SHALL have port oPIX_DATA, output, DATA_W bits: FIFO head word (show-ahead).
REQ-018 SHALL have port oPIX_VALID, output, 1 bit: FIFO non-empty.
REQ-019 SHALL have port oUNDERRUN, output, 1 bit: sticky flag for a pop attempted while empty.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT.
- IDLE->REQ when iENABLE=1 and (free FIFO entries) >= BURST_LEN.
- REQ->WAIT on the cycle iRD_GNT=1.
- WAIT->IDLE after the BURST_LEN-th iRD_DATA_VALID.
REQ-021 SHALL hold oRD_REQ=1 and oRD_ADDR stable throughout REQ; oRD_REQ=0 in IDLE and WAIT.
REQ-022 SHALL allow at most one burst outstanding; the free-space check guarantees the FIFO never overflows.
REQ-023 SHALL advance the address by BURST_LEN on each grant; the address after BASE_ADDR+FRAME_WORDS-BURST_LEN SHALL be BASE_ADDR (wrap).
REQ-024 SHALL write each iRD_DATA into the FIFO on iRD_DATA_VALID in WAIT; iRD_DATA_VALID in IDLE or REQ SHALL be ignored.
REQ-025 SHALL make a word written at cycle N visible on oPIX_DATA/oPIX_VALID at cycle N+1.
REQ-026 SHALL pop on iPIX_REQ&&oPIX_VALID; a simultaneous push and pop SHALL leave the count unchanged.
REQ-027 SHALL ignore iPIX_REQ with oPIX_VALID=0, leave the FIFO unchanged and set oUNDERRUN=1.
REQ-028 oUNDERRUN SHALL stay set until iFRAME_START or reset.
REQ-029 On iFRAME_START:
- flush the FIFO (oPIX_VALID=0 next cycle);
- clear oUNDERRUN;
- set the next address to BASE_ADDR;
- from REQ, deassert oRD_REQ and go to IDLE;
- from WAIT, discard the remaining words of the in-flight burst, then go to IDLE.
REQ-030 iFRAME_START on the same cycle as iRD_GNT SHALL treat the grant as accepted and discard that whole burst.
REQ-031 Deasserting iENABLE SHALL block only new requests; an in-flight burst SHALL complete.

Reset
REQ-032 While iRESETn=0 SHALL force the following:
- FSM=IDLE;
- oRD_REQ=0, oRD_ADDR=BASE_ADDR;
- FIFO empty, oPIX_VALID=0, oPIX_DATA=0;
- oUNDERRUN=0;
- discard counter=0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; the controller side is reset by the same iRESETn.

Structure
REQ-034 SHALL place the FSM state enum and default burst/width constants in shared package sdram_pkg.
REQ-035 SHALL instantiate one sub-module sync_fifo (single clock, show-ahead, with count output and flush input).

Verification
REQ-036 Reset then iENABLE=1 with BASE_ADDR=0 -> oRD_REQ=1 with oRD_ADDR=0; after grant and 8 valids, the next request has oRD_ADDR=8.
REQ-037 FRAME_WORDS=16, BURST_LEN=8, continuous pops -> request addresses 0,8,0,8.
REQ-038 Grant withheld 20 cycles -> oRD_REQ and oRD_ADDR stable all 20 cycles; exactly one burst is accepted.
REQ-039 No pops, FIFO_DEPTH=32 -> exactly 4 bursts, count reaches 32, no further oRD_REQ; one pop of 8 words -> next request issued.
REQ-040 iFRAME_START after 3 of 8 valids -> 5 words discarded, FIFO empty, next oRD_ADDR=BASE_ADDR.
REQ-041 iPIX_REQ on empty FIFO -> oUNDERRUN=1 and held; iFRAME_START -> oUNDERRUN=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM frame reader: read-agent FSM states and
// default geometry of the SDRAM port and the burst buffer.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } rd_state_e;

    localparam int SDRAM_ADDR_W      = 22;
    localparam int SDRAM_DATA_W      = 16;
    localparam int SDRAM_BURST_LEN   = 8;
    localparam int SDRAM_FIFO_DEPTH  = 32;
    localparam int SDRAM_FRAME_WORDS = 19200;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is presented combinationally,
// so a word pushed on one edge is visible right after it. Flush beats push/pop.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/sdram_frame_reader.sv
// Streams a frame out of SDRAM in fixed bursts into a show-ahead pixel FIFO,
// one burst outstanding at a time, only requested when the whole burst fits.
module sdram_frame_reader
    import sdram_pkg::*;
#(
    parameter int ADDR_W      = SDRAM_ADDR_W,
    parameter int DATA_W      = SDRAM_DATA_W,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = SDRAM_FRAME_WORDS,
    parameter int BURST_LEN   = SDRAM_BURST_LEN,
    parameter int FIFO_DEPTH  = SDRAM_FIFO_DEPTH
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iENABLE,
    input  logic              iFRAME_START,
    output logic              oRD_REQ,
    input  logic              iRD_GNT,
    output logic [ADDR_W-1:0] oRD_ADDR,
    input  logic [DATA_W-1:0] iRD_DATA,
    input  logic              iRD_DATA_VALID,
    input  logic              iPIX_REQ,
    output logic [DATA_W-1:0] oPIX_DATA,
    output logic              oPIX_VALID,
    output logic              oUNDERRUN
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FRAME_WORDS - BURST_LEN);

    rd_state_e         state_q;
    logic              rd_req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] next_addr_d;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] discard_q;
    logic              underrun_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              space_ok;
    logic              last_beat;
    logic              fifo_push_d;
    logic              fifo_pop_d;

    assign next_addr_d = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + ADDR_W'(BURST_LEN);
    assign space_ok    = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(BURST_LEN);
    assign last_beat   = (beat_q == BEAT_W'(BURST_LEN - 1));

    // Words still owed by a burst cut short by a frame restart never reach the FIFO.
    assign fifo_push_d = (state_q == ST_WAIT) && iRD_DATA_VALID
                         && (discard_q == '0) && !iFRAME_START;
    assign fifo_pop_d  = iPIX_REQ && oPIX_VALID;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q   <= ST_IDLE;
            rd_req_q  <= 1'b0;
            addr_q    <= FIRST_ADDR;
            beat_q    <= '0;
            discard_q <= '0;
        end else begin
            if (iFRAME_START) begin
                addr_q <= FIRST_ADDR;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!iFRAME_START && iENABLE && space_ok) begin
                        state_q  <= ST_REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (iRD_GNT) begin
                        state_q  <= ST_WAIT;
                        rd_req_q <= 1'b0;
                        beat_q   <= '0;
                        if (iFRAME_START) begin
                            discard_q <= BEAT_W'(BURST_LEN);
                        end else begin
                            discard_q <= '0;
                            addr_q    <= next_addr_d;
                        end
                    end else if (iFRAME_START) begin
                        state_q  <= ST_IDLE;
                        rd_req_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (iRD_DATA_VALID) begin
                        if (last_beat) begin
                            state_q   <= ST_IDLE;
                            beat_q    <= '0;
                            discard_q <= '0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                            if (iFRAME_START) begin
                                discard_q <= BEAT_W'(BURST_LEN) - beat_q - BEAT_W'(1);
                            end else if (discard_q != '0) begin
                                discard_q <= discard_q - BEAT_W'(1);
                            end
                        end
                    end else if (iFRAME_START) begin
                        discard_q <= BEAT_W'(BURST_LEN) - beat_q;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rd_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            underrun_q <= 1'b0;
        end else if (iFRAME_START) begin
            underrun_q <= 1'b0;
        end else if (iPIX_REQ && !oPIX_VALID) begin
            underrun_q <= 1'b1;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iCLK),
        .rst_n   (iRESETn),
        .flush_i (iFRAME_START),
        .push_i  (fifo_push_d),
        .data_i  (iRD_DATA),
        .pop_i   (fifo_pop_d),
        .data_o  (oPIX_DATA),
        .valid_o (oPIX_VALID),
        .count_o (fifo_count)
    );

    assign oRD_REQ   = rd_req_q;
    assign oRD_ADDR  = addr_q;
    assign oUNDERRUN = underrun_q;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader: a bench-side controller model drives
// grants and bursts, a scoreboard checks granted addresses and popped words.
module tb_sdram_frame_reader;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int BASE   = 0;
    localparam int FW     = 16;
    localparam int BL     = 8;
    localparam int DEPTH  = 32;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              en      = 1'b0;
    logic              fs      = 1'b0;
    logic              gnt     = 1'b0;
    logic              dv      = 1'b0;
    logic              pix_req = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              underrun;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [DATA_W-1:0] exp_data_q [$];
    logic [DATA_W-1:0] seq = 16'h1000;

    sdram_frame_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .iCLK           (clk),
        .iRESETn        (rst_n),
        .iENABLE        (en),
        .iFRAME_START   (fs),
        .oRD_REQ        (rd_req),
        .iRD_GNT        (gnt),
        .oRD_ADDR       (rd_addr),
        .iRD_DATA       (rd_data),
        .iRD_DATA_VALID (dv),
        .iPIX_REQ       (pix_req),
        .oPIX_DATA      (pix_data),
        .oPIX_VALID     (pix_valid),
        .oUNDERRUN      (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_req(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
        tick();
    endtask

    task automatic grant(input logic [ADDR_W-1:0] a);
        exp_addr_q.push_back(a);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
    endtask

    task automatic send(input int n, input bit keep, input bit pop_too);
        for (int i = 0; i < n; i++) begin
            rd_data = seq;
            dv      = 1'b1;
            if (keep) exp_data_q.push_back(seq);
            seq = seq + 16'd1;
            if (pop_too && i > 0) pix_req = 1'b1;
            tick();
        end
        dv = 1'b0;
        if (pop_too) begin
            pix_req = 1'b1;
            tick();
            pix_req = 1'b0;
        end
    endtask

    task automatic pop_n(input int n);
        pix_req = 1'b1;
        repeat (n) tick();
        pix_req = 1'b0;
    endtask

    task automatic no_req_for(input int n, input string name);
        int hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rd_req !== 1'b0) hits++;
        end
        chk(name, hits, 0);
        tick();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (gnt && rd_req) begin
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_grant", 32'd1, 32'd0);
                    end else begin
                        logic [ADDR_W-1:0] ea;
                        ea = exp_addr_q.pop_front();
                        $display("grant addr=%0h expected=%0h", rd_addr, ea);
                        chk("grant_addr", {10'd0, rd_addr}, {10'd0, ea});
                    end
                end
                if (pix_req && pix_valid) begin
                    if (exp_data_q.size() == 0) begin
                        chk("unexpected_pop", 32'd1, 32'd0);
                    end else begin
                        logic [DATA_W-1:0] ed;
                        ed = exp_data_q.pop_front();
                        $display("pop data=%0h expected=%0h", pix_data, ed);
                        chk("pop_data", {16'd0, pix_data}, {16'd0, ed});
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, rd_req}, 32'd0);
        chk("rst_addr", {10'd0, rd_addr}, BASE);
        chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_pix_data", {16'd0, pix_data}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First burst at 0, second at 8 with grant withheld 20 cycles
        en = 1'b1;
        wait_req("req_first");
        grant(0);
        send(BL, 1'b1, 1'b0);
        wait_req("req_second");
        begin
            int bad_hold = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rd_req !== 1'b1 || rd_addr !== ADDR_W'(8)) bad_hold++;
                tick();
            end
            chk("hold_req_addr_20", bad_hold, 0);
        end
        grant(8);
        @(negedge clk);
        chk("req_drop_after_gnt", {31'd0, rd_req}, 32'd0);
        tick();
        send(BL, 1'b1, 1'b0);

        // Fill: third and fourth bursts wrap to 0,8; then FIFO is full
        wait_req("req_third");
        grant(0);
        send(BL, 1'b1, 1'b0);
        wait_req("req_fourth");
        grant(8);
        send(BL, 1'b1, 1'b0);
        no_req_for(20, "no_req_when_full");
        pop_n(BL);
        wait_req("req_after_pop8");
        pop_n(24);
        chk("empty_after_drain", {31'd0, pix_valid}, 32'd0);

        // Frame restart after 3 of 8 words
        grant(0);
        send(3, 1'b0, 1'b0);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        @(negedge clk);
        chk("flush_pix_valid", {31'd0, pix_valid}, 32'd0);
        tick();
        send(5, 1'b0, 1'b0);
        @(negedge clk);
        chk("discard_no_write", {31'd0, pix_valid}, 32'd0);
        tick();
        wait_req("req_after_restart");
        grant(0);
        en = 1'b0;
        send(BL, 1'b1, 1'b0);
        no_req_for(10, "no_req_when_disabled");
        pop_n(BL);
        @(negedge clk);
        chk("empty_after_pop", {31'd0, pix_valid}, 32'd0);
        tick();

        // Data valid outside WAIT is ignored
        send(2, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_valid_ignored", {31'd0, pix_valid}, 32'd0);
        tick();

        // Simultaneous push and pop
        en = 1'b1;
        wait_req("req_stream");
        grant(8);
        send(BL, 1'b1, 1'b1);
        @(negedge clk);
        chk("stream_empty", {31'd0, pix_valid}, 32'd0);
        chk("stream_no_underrun", {31'd0, underrun}, 32'd0);
        tick();

        // Frame restart coinciding with grant discards the whole burst
        wait_req("req_before_gnt_fs");
        exp_addr_q.push_back(0);
        gnt = 1'b1;
        fs  = 1'b1;
        tick();
        gnt = 1'b0;
        fs  = 1'b0;
        send(BL, 1'b0, 1'b0);
        @(negedge clk);
        chk("gnt_fs_discard", {31'd0, pix_valid}, 32'd0);
        tick();
        wait_req("req_after_gnt_fs");
        @(negedge clk);
        chk("addr_after_gnt_fs", {10'd0, rd_addr}, BASE);
        tick();
        fs = 1'b1;
        en = 1'b0;
        tick();
        fs = 1'b0;
        @(negedge clk);
        chk("req_drop_on_fs", {31'd0, rd_req}, 32'd0);
        tick();

        // Underrun is sticky until frame restart
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        @(negedge clk);
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        chk("underrun_fifo_empty", {31'd0, pix_valid}, 32'd0);
        tick();
        repeat (5) tick();
        @(negedge clk);
        chk("underrun_held", {31'd0, underrun}, 32'd1);
        tick();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        @(negedge clk);
        chk("underrun_cleared", {31'd0, underrun}, 32'd0);

        chk("addr_queue_drained", exp_addr_q.size(), 0);
        chk("data_queue_drained", exp_data_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
